// File: rtl/fixed_accumulator.sv
// Streaming unsigned accumulator: sums IN_DEPTH beats per result, valid/ready both sides.
// Optional FIXED_ACCUMULATOR_LAST_EN adds data_in_last to close a group early.
module fixed_accumulator #(
    parameter int IN_WIDTH  = 32,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_WIDTH = IN_WIDTH + $clog2(IN_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic                 data_in_valid,
`ifdef FIXED_ACCUMULATOR_LAST_EN
    input  logic                 data_in_last,
`endif
    output logic                 data_in_ready,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready
);

    localparam int CW = $clog2(IN_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(IN_DEPTH);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t               state;
    logic [OUT_WIDTH-1:0] acc;
    logic [CW-1:0]        count;

    logic                 in_hs;
    logic                 out_hs;
    logic                 start;
    logic                 last_beat;
    logic                 close;
    logic [CW-1:0]        next_count;
    logic [OUT_WIDTH-1:0] beat_ext;

`ifdef FIXED_ACCUMULATOR_LAST_EN
    assign last_beat = data_in_last;
`else
    assign last_beat = 1'b0;
`endif

    // Reset gates ready so nothing is offered upstream while rst is low.
    assign data_in_ready  = rst && ((state == ACCUM) || data_out_ready);
    assign data_out_valid = (state == HOLD);
    assign data_out       = acc;

    assign in_hs      = data_in_valid && data_in_ready;
    assign out_hs     = data_out_valid && data_out_ready;
    assign start      = (count == '0);
    assign next_count = start ? CW'(1) : count + CW'(1);
    assign close      = (next_count == DEPTH_C) || last_beat;
    assign beat_ext   = OUT_WIDTH'(data_in);

    // count is 0 in HOLD, so a beat taken while draining always restarts acc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACCUM;
            acc   <= '0;
            count <= '0;
        end else if (in_hs) begin
            acc <= start ? beat_ext : acc + beat_ext;
            if (close) begin
                count <= '0;
                state <= HOLD;
            end else begin
                count <= next_count;
                state <= ACCUM;
            end
        end else if (out_hs) begin
            state <= ACCUM;
        end
    end

endmodule
